icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/icache.sv | 138 +++++++++++++
 tb/tb_icache.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with one 32-bit word per frame.
// A miss parks the FSM in FILL until memory answers; inv drops every frame at once.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  input  logic        inv,
  output logic [15:0] miss_count
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [15:0] miss_count_q, miss_count_d;

  logic [SETS-1:0] valid_q;
  logic [25:0]     tag_q  [SETS];
  logic [31:0]     data_q [SETS];

  logic [3:0]  idx_s;
  logic [3:0]  fill_idx_s;
  logic [25:0] tag_s;
  logic        hit_s;
  logic        fill_done_s;
  logic        unused_s;

  // Byte offset bits never select anything in a word-per-frame cache.
  assign unused_s = ^{imemaddr[1:0], miss_addr_q[1:0]};

  // Address decode, hit detection and datapath-facing outputs.
  always_comb begin
    idx_s       = imemaddr[5:2];
    tag_s       = imemaddr[31:6];
    fill_idx_s  = miss_addr_q[5:2];
    hit_s       = 1'b0;
    fill_done_s = 1'b0;
    if (state_q == IDLE) begin
      hit_s = imemREN & valid_q[idx_s] & (tag_q[idx_s] == tag_s);
    end else begin
      fill_done_s = ~iwait;
    end
    ihit = hit_s;
    if (hit_s) begin
      imemload = data_q[idx_s];
    end else begin
      imemload = 32'h0000_0000;
    end
  end

  // Memory-facing request is a pure function of the registered state.
  always_comb begin
    if (state_q == FILL) begin
      iREN  = 1'b1;
      iaddr = {miss_addr_q[31:2], 2'b00};
    end else begin
      iREN  = 1'b0;
      iaddr = 32'h0000_0000;
    end
    miss_count = miss_count_q;
  end

  // Next-state logic for the miss/fill controller.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    miss_count_d = miss_count_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit_s) begin
          state_d      = FILL;
          miss_addr_d  = imemaddr;
          miss_count_d = miss_count_q + 16'd1;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // A fill always runs to completion; only reset can abandon it.
        if (!iwait) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, captured miss address and miss counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      miss_addr_q  <= 32'h0000_0000;
      miss_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Valid bits: invalidate wins over a fill landing in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= {SETS{1'b0}};
    end else if (inv) begin
      valid_q <= {SETS{1'b0}};
    end else if (fill_done_s) begin
      valid_q[fill_idx_s] <= 1'b1;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag and data arrays carry no reset; valid qualifies them.
  always_ff @(posedge CLK) begin
    if (nRST && fill_done_s) begin
      tag_q[fill_idx_s]  <= miss_addr_q[31:6];
      data_q[fill_idx_s] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios followed by random traffic,
// all compared against a frame-table reference model kept in the bench.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        inv;
  logic [15:0] miss_count;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .inv(inv), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame table plus one outstanding-miss record.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [31:0] m_pend;
  logic [15:0] m_count;

  logic        obs_hit;
  logic [31:0] obs_load;
  logic [15:0] obs_cnt;
  logic        obs_ren;

  task automatic chk(input string tg, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tg, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_busy  = 1'b0;
    m_pend  = 32'h0;
    m_count = 16'h0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cyc(input bit rst_n, input bit ren, input logic [31:0] addr,
                     input bit wt, input logic [31:0] ld, input bit iv);
    logic [3:0]  ix;
    logic [25:0] tg;
    bit          eh;
    @(negedge CLK);
    nRST = rst_n; imemREN = ren; imemaddr = addr; iwait = wt; iload = ld; inv = iv;
    #1;
    ix = addr[5:2];
    tg = addr[31:6];
    eh = !m_busy && ren && m_valid[ix] && (m_tag[ix] == tg);
    chk("ihit", {31'h0, ihit}, {31'h0, eh});
    chk("imemload", imemload, eh ? m_data[ix] : 32'h0);
    chk("iREN", {31'h0, iREN}, {31'h0, m_busy});
    chk("iaddr", iaddr, m_busy ? {m_pend[31:2], 2'b00} : 32'h0);
    chk("miss_count", {16'h0, miss_count}, {16'h0, m_count});
    obs_hit = ihit; obs_load = imemload; obs_cnt = miss_count; obs_ren = iREN;
    @(posedge CLK);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_busy) begin
        if (!wt) begin
          m_valid[m_pend[5:2]] = 1'b1;
          m_tag[m_pend[5:2]]   = m_pend[31:6];
          m_data[m_pend[5:2]]  = ld;
          m_busy = 1'b0;
        end
      end else if (ren && !eh) begin
        m_busy  = 1'b1;
        m_pend  = addr;
        m_count = m_count + 16'd1;
      end
      if (iv) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      end
    end
  endtask

  // Miss on addr, hold iwait for nwait cycles, then return word.
  task automatic do_fill(input logic [31:0] addr, input int nwait, input logic [31:0] word);
    cyc(1'b1, 1'b1, addr, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < nwait; k++) cyc(1'b1, 1'b1, addr, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b1, 1'b1, addr, 1'b0, word, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [25:0] tg;
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iwait = 1'b1; iload = 32'h0; inv = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Reset state
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("rst_cnt", {16'h0, obs_cnt}, 32'h0);

    // Cold miss with three wait cycles, then hit
    do_fill(32'h0000_0040, 3, 32'h8C01_0004);
    cyc(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0, 1'b0);
    chk("cold_hit", {31'h0, obs_hit}, 32'h1);
    chk("cold_load", obs_load, 32'h8C01_0004);
    chk("cold_cnt", {16'h0, obs_cnt}, 32'h1);
    cyc(1'b1, 1'b1, 32'h0000_0043, 1'b1, 32'h0, 1'b0);
    chk("hit_ren", {31'h0, obs_ren}, 32'h0);
    chk("hit_cnt", {16'h0, obs_cnt}, 32'h1);

    // Conflict on index 0
    do_fill(32'h0000_0080, 1, 32'h1111_2222);
    do_fill(32'h0000_0040, 0, 32'h8C01_0004);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    chk("conflict_cnt", {16'h0, obs_cnt}, 32'h3);

    // Invalidate pulse
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0, 1'b0);
    chk("inv_miss", {31'h0, obs_hit}, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h5555_AAAA, 1'b0);
    chk("inv_fill", {31'h0, obs_ren}, 32'h1);

    // Invalidate coinciding with fill completion of 0x44
    cyc(1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_0044, 1'b0, 32'h7777_0044, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0, 1'b0);
    chk("inv_fill_miss", {31'h0, obs_hit}, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0044, 1'b0, 32'h7777_0044, 1'b0);

    // Reset in the middle of a fill of 0x100
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0BAD_0100, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0, 1'b0);
    chk("rst_fill_ren", {31'h0, obs_ren}, 32'h0);
    chk("rst_fill_cnt", {16'h0, obs_cnt}, 32'h0);
    chk("rst_fill_miss", {31'h0, obs_hit}, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);

    // Random traffic over a small tag pool so hits, conflicts and refills all occur
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 2))
        0: tg = 26'h0;
        1: tg = 26'h1;
        default: tg = 26'h3FF_FFFF;
      endcase
      a = {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), a,
          ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
